// File: rtl/dfp_arbiter_if.sv
// Signal bundle joining the I-cache and D-cache downward ports, the line arbiter and the memory burst port.
// The arbiter connects through the slave modport; the cache/memory side uses master.
interface dfp_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
);
    logic [ADDR_WIDTH-1:0] ic_addr;
    logic                  ic_read;
    logic [LINE_WIDTH-1:0] ic_rdata;
    logic                  ic_resp;

    logic [ADDR_WIDTH-1:0] dc_addr;
    logic                  dc_read;
    logic                  dc_write;
    logic [LINE_WIDTH-1:0] dc_wdata;
    logic [LINE_WIDTH-1:0] dc_rdata;
    logic                  dc_resp;

    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_read;
    logic                  mem_write;
    logic [LINE_WIDTH-1:0] mem_wdata;
    logic [LINE_WIDTH-1:0] mem_rdata;
    logic                  mem_resp;

    modport slave (
        input  ic_addr, ic_read,
        input  dc_addr, dc_read, dc_write, dc_wdata,
        input  mem_rdata, mem_resp,
        output ic_rdata, ic_resp,
        output dc_rdata, dc_resp,
        output mem_addr, mem_read, mem_write, mem_wdata
    );

    modport master (
        output ic_addr, ic_read,
        output dc_addr, dc_read, dc_write, dc_wdata,
        output mem_rdata, mem_resp,
        input  ic_rdata, ic_resp,
        input  dc_rdata, dc_resp,
        input  mem_addr, mem_read, mem_write, mem_wdata
    );
endinterface

// File: rtl/dfp_arbiter.sv
// Round-robin arbiter sharing one line-granular memory port between the I-cache and D-cache.
// One 256-bit read or writeback is outstanding at a time; the grant is held until mem_resp.
module dfp_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int LINE_WIDTH    = 256,
    parameter bit RESET_FAVOR_D = 1'b1
) (
    input  logic         clk,
    input  logic         rst_n,
    dfp_arbiter_if.slave bus,
    output logic         busy
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] BUSY_I = 2'd1;
    localparam logic [1:0] BUSY_D = 2'd2;
    localparam int TAG_WIDTH = ADDR_WIDTH - 5;

    logic [1:0]            state;
    logic [1:0]            state_next;
    logic                  last_d;
    logic                  blk_i;
    logic                  blk_d;
    logic [TAG_WIDTH-1:0]  addr_q;
    logic                  write_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic want_i;
    logic want_d;
    logic grant_i;
    logic grant_d;
    logic resp_i;
    logic resp_d;
    logic unused_addr_low;

    // A requester just served is held off for one cycle: its request line may still be high.
    assign want_i  = bus.ic_read && !blk_i;
    assign want_d  = (bus.dc_read || bus.dc_write) && !blk_d;
    assign grant_d = (state == IDLE) && want_d && (!want_i || !last_d);
    assign grant_i = (state == IDLE) && want_i && !grant_d;

    assign resp_i  = (state == BUSY_I) && bus.mem_resp;
    assign resp_d  = (state == BUSY_D) && bus.mem_resp;

    always_comb begin
        // NOTE: state_next gets its default first, so no path through this block can infer a latch.
        state_next = state;
        if (grant_d) begin
            state_next = BUSY_D;
        end else if (grant_i) begin
            state_next = BUSY_I;
        end else if (resp_i || resp_d) begin
            state_next = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            last_d  <= !RESET_FAVOR_D;
            blk_i   <= 1'b0;
            blk_d   <= 1'b0;
            // NOTE: the capture registers are reset as well, so mem_addr/mem_wdata read 0 after reset.
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state <= state_next;
            blk_i <= resp_i;
            blk_d <= resp_d;
            if (grant_d) begin
                last_d  <= 1'b1;
                addr_q  <= bus.dc_addr[ADDR_WIDTH-1:5];
                write_q <= bus.dc_write;
                wdata_q <= bus.dc_write ? bus.dc_wdata : '0;
            end else if (grant_i) begin
                last_d  <= 1'b0;
                addr_q  <= bus.ic_addr[ADDR_WIDTH-1:5];
                write_q <= 1'b0;
                wdata_q <= '0;
            end
        end
    end

    assign busy          = (state != IDLE);
    assign bus.mem_addr  = {addr_q, 5'b0};
    assign bus.mem_read  = busy && !write_q;
    assign bus.mem_write = busy && write_q;
    assign bus.mem_wdata = wdata_q;

    // Writebacks return an all-zero line; rdata is zero whenever resp is low.
    assign bus.ic_resp   = resp_i;
    assign bus.ic_rdata  = resp_i ? bus.mem_rdata : '0;
    assign bus.dc_resp   = resp_d;
    assign bus.dc_rdata  = (resp_d && !write_q) ? bus.mem_rdata : '0;

    assign unused_addr_low = ^{bus.ic_addr[4:0], bus.dc_addr[4:0]};
endmodule

// File: tb/tb_dfp_arbiter.sv
// Bench for dfp_arbiter: directed cycle table, a hand-driven protocol-violation sequence,
// then randomized traffic compared against a transaction-level reference model.
module tb_dfp_arbiter;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam bit FAVOR_D = 1'b1;
    localparam logic L = 1'b0;
    localparam logic H = 1'b1;

    typedef logic [LW-1:0] line_t;
    typedef logic [AW-1:0] addr_t;

    typedef struct {
        logic  rst_n;
        logic  ir;
        addr_t ia;
        logic  dr;
        logic  dw;
        addr_t da;
        line_t dwd;
        logic  mr;
        line_t mrd;
        logic  e_rd;
        logic  e_wr;
        addr_t e_addr;
        logic  e_ir;
        logic  e_dr;
        logic  e_busy;
        line_t e_rdata;
        line_t e_wd;
        logic  e_zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic busy;
    always #5 clk = ~clk;

    dfp_arbiter_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) bus ();

    dfp_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW), .RESET_FAVOR_D(FAVOR_D)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave),
        .busy (busy)
    );

    int vectors = 0;
    int miscompares = 0;
    vec_t tbl[$];
    line_t z, a5, w1, w2, r2;

    // Reference model state: who owns the port, who was served last, when each may be granted again.
    int    owner;
    int    last;
    int    ready_at[3];
    int    now;
    int    mem_wait;
    addr_t cap_addr;
    line_t cap_wd;
    logic  cap_wr;
    logic  i_pend, d_pend, i_linger, d_linger, r_rst;
    int    waited;

    task automatic check(input string name, input line_t act, input line_t exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic e_rd, e_wr, input addr_t e_addr,
                                 input logic e_ir, e_dr, e_busy, input line_t e_ird, e_drd, e_wd);
        check({tag, " mem_read"},  line_t'(bus.mem_read),  line_t'(e_rd));
        check({tag, " mem_write"}, line_t'(bus.mem_write), line_t'(e_wr));
        check({tag, " ic_resp"},   line_t'(bus.ic_resp),   line_t'(e_ir));
        check({tag, " dc_resp"},   line_t'(bus.dc_resp),   line_t'(e_dr));
        check({tag, " busy"},      line_t'(busy),          line_t'(e_busy));
        check({tag, " ic_rdata"},  bus.ic_rdata, e_ird);
        check({tag, " dc_rdata"},  bus.dc_rdata, e_drd);
        if (e_rd || e_wr) check({tag, " mem_addr"}, line_t'(bus.mem_addr), line_t'(e_addr));
        if (e_wr) check({tag, " mem_wdata"}, bus.mem_wdata, e_wd);
    endtask

    function automatic vec_t mk(input logic r, ir, input addr_t ia, input logic dr, dw, input addr_t da,
                                input line_t dwd, input logic mr, input line_t mrd,
                                input logic erd, ewr, input addr_t ea, input logic eir, edr, eb,
                                input line_t erdata, ewd, input logic ez);
        vec_t v;
        v.rst_n = r;  v.ir = ir;   v.ia = ia;     v.dr = dr;   v.dw = dw;   v.da = da;
        v.dwd = dwd;  v.mr = mr;   v.mrd = mrd;   v.e_rd = erd; v.e_wr = ewr; v.e_addr = ea;
        v.e_ir = eir; v.e_dr = edr; v.e_busy = eb; v.e_rdata = erdata; v.e_wd = ewd; v.e_zero = ez;
        return v;
    endfunction

    function automatic line_t rand_line();
        line_t l;
        for (int k = 0; k < LW / 32; k++) l[k*32 +: 32] = $urandom;
        return l;
    endfunction

    initial begin
        z  = '0;
        a5 = {32{8'hA5}};
        w1 = {8{32'h1234_5678}};
        w2 = {8{32'hCAFE_F00D}};
        r2 = {8{32'h0BAD_BEEF}};

        rst_n = L;
        bus.ic_addr = '0; bus.ic_read = L;
        bus.dc_addr = '0; bus.dc_read = L; bus.dc_write = L; bus.dc_wdata = '0;
        bus.mem_rdata = '0; bus.mem_resp = L;

        // Reset state, then a single I read answered 3 cycles after mem_read, held one cycle past resp.
        tbl.push_back(mk(H, L, 0,            L, L, 0, z, L, z,  L, L, 0,            L, L, L, z,  z,  H));
        tbl.push_back(mk(H, H, 32'h1000_0024, L, L, 0, z, L, z,  L, L, 0,            L, L, L, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0024, L, L, 0, z, L, a5, H, L, 32'h1000_0020, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0024, L, L, 0, z, L, a5, H, L, 32'h1000_0020, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0024, L, L, 0, z, L, a5, H, L, 32'h1000_0020, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0024, L, L, 0, z, H, a5, H, L, 32'h1000_0020, H, L, H, a5, z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0024, L, L, 0, z, L, a5, L, L, 0,            L, L, L, z,  z,  L));
        tbl.push_back(mk(H, L, 0,            L, L, 0, z, L, z,  L, L, 0,            L, L, L, z,  z,  L));
        // Ties after reset: D first, I right after dc_resp, then D, then I.
        tbl.push_back(mk(L, L, 0,            L, L, 0, z, L, z,  L, L, 0,            L, L, L, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, L, z,  L, L, 0,  L, L, L, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, L, z,  H, L, 32'h2000_0200, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, H, r2, H, L, 32'h2000_0200, L, H, H, r2, z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, L, z,  L, L, 0,  L, L, L, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, L, z,  H, L, 32'h1000_0100, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, H, a5, H, L, 32'h1000_0100, H, L, H, a5, z,  L));
        tbl.push_back(mk(H, L, 32'h1000_0100, L, L, 32'h2000_0200, z, L, z,  L, L, 0,  L, L, L, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, L, z,  L, L, 0,  L, L, L, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, L, z,  H, L, 32'h2000_0200, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, H, r2, H, L, 32'h2000_0200, L, H, H, r2, z,  L));
        tbl.push_back(mk(H, L, 32'h1000_0100, L, L, 32'h2000_0200, z, L, z,  L, L, 0,  L, L, L, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, L, z,  L, L, 0,  L, L, L, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, L, z,  H, L, 32'h1000_0100, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, H, 32'h1000_0100, H, L, 32'h2000_0200, z, H, a5, H, L, 32'h1000_0100, H, L, H, a5, z,  L));
        tbl.push_back(mk(H, L, 0,            L, L, 0, z, L, z,  L, L, 0,            L, L, L, z,  z,  L));
        // Dirty miss: writeback with inputs changing mid-transaction, one blocked cycle, then the refill read.
        tbl.push_back(mk(H, L, 0, L, H, 32'h2000_0040, w1, L, z,  L, L, 0,             L, L, L, z,  z,  L));
        tbl.push_back(mk(H, L, 0, L, H, 32'h5555_5555, w2, L, z,  L, H, 32'h2000_0040, L, L, H, z,  w1, L));
        tbl.push_back(mk(H, L, 0, L, H, 32'h5555_5555, w2, L, z,  L, H, 32'h2000_0040, L, L, H, z,  w1, L));
        tbl.push_back(mk(H, L, 0, L, H, 32'h5555_5555, w2, H, r2, L, H, 32'h2000_0040, L, H, H, z,  w1, L));
        tbl.push_back(mk(H, L, 0, H, L, 32'h3000_0040, z,  L, z,  L, L, 0,             L, L, L, z,  z,  L));
        tbl.push_back(mk(H, L, 0, H, L, 32'h3000_0040, z,  L, z,  L, L, 0,             L, L, L, z,  z,  L));
        tbl.push_back(mk(H, L, 0, H, L, 32'h3000_0040, z,  L, z,  H, L, 32'h3000_0040, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, L, 0, H, L, 32'h3000_0040, z,  H, a5, H, L, 32'h3000_0040, L, H, H, a5, z,  L));
        tbl.push_back(mk(H, L, 0, L, L, 0,             z,  L, z,  L, L, 0,             L, L, L, z,  z,  L));
        // Reset while BUSY_D, followed by a stale mem_resp.
        tbl.push_back(mk(H, L, 0, H, L, 32'h4000_0000, z,  L, z,  L, L, 0,             L, L, L, z,  z,  L));
        tbl.push_back(mk(H, L, 0, H, L, 32'h4000_0000, z,  L, z,  H, L, 32'h4000_0000, L, L, H, z,  z,  L));
        tbl.push_back(mk(L, L, 0, H, L, 32'h4000_0000, z,  L, z,  H, L, 32'h4000_0000, L, L, H, z,  z,  L));
        tbl.push_back(mk(H, L, 0, L, L, 0,             z,  H, a5, L, L, 0,             L, L, L, z,  z,  H));
        tbl.push_back(mk(H, L, 0, L, L, 0,             z,  L, z,  L, L, 0,             L, L, L, z,  z,  L));

        repeat (2) @(posedge clk);

        foreach (tbl[i]) begin
            @(posedge clk);
            #1;
            rst_n         = tbl[i].rst_n;
            bus.ic_read   = tbl[i].ir;
            bus.ic_addr   = tbl[i].ia;
            bus.dc_read   = tbl[i].dr;
            bus.dc_write  = tbl[i].dw;
            bus.dc_addr   = tbl[i].da;
            bus.dc_wdata  = tbl[i].dwd;
            bus.mem_resp  = tbl[i].mr;
            bus.mem_rdata = tbl[i].mrd;
            #1;
            check_outputs($sformatf("tbl[%0d]", i), tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_addr,
                          tbl[i].e_ir, tbl[i].e_dr, tbl[i].e_busy,
                          tbl[i].e_ir ? tbl[i].e_rdata : z, tbl[i].e_dr ? tbl[i].e_rdata : z, tbl[i].e_wd);
            if (tbl[i].e_zero) begin
                check($sformatf("tbl[%0d] mem_addr after reset", i), line_t'(bus.mem_addr), z);
                check($sformatf("tbl[%0d] mem_wdata after reset", i), bus.mem_wdata, z);
            end
        end

        // dc_read and dc_write together: the write must be granted, the read ignored.
        @(posedge clk);
        #1;
        bus.dc_addr = 32'h6000_0013; bus.dc_read = H; bus.dc_write = H; bus.dc_wdata = w2;
        $display("note: dc_read and dc_write driven together on purpose (protocol violation)");
        waited = 0;
        do begin
            @(posedge clk);
            #2;
            waited++;
        end while (!(bus.mem_read || bus.mem_write) && waited < 8);
        check("viol grant latency", line_t'(waited), line_t'(1));
        check("viol mem_write", line_t'(bus.mem_write), line_t'(H));
        check("viol mem_read", line_t'(bus.mem_read), line_t'(L));
        check("viol mem_addr", line_t'(bus.mem_addr), line_t'(32'h6000_0000));
        check("viol mem_wdata", bus.mem_wdata, w2);
        bus.mem_resp = H; bus.mem_rdata = r2;
        #1;
        check("viol dc_resp", line_t'(bus.dc_resp), line_t'(H));
        check("viol dc_rdata", bus.dc_rdata, z);
        check("viol ic_resp", line_t'(bus.ic_resp), line_t'(L));
        @(posedge clk);
        #1;
        bus.mem_resp = L; bus.dc_read = L; bus.dc_write = L;
        #1;
        check("viol busy after resp", line_t'(busy), line_t'(L));

        // Randomized traffic against the reference model.
        owner = 0; last = 1; ready_at = '{0, 0, 0}; now = 0; mem_wait = -1;
        cap_addr = '0; cap_wd = '0; cap_wr = L;
        i_pend = L; d_pend = L; i_linger = L; d_linger = L;
        for (int n = 0; n < 3000; n++) begin
            logic e_ir, e_dr, ei, ed;
            int win;
            @(posedge clk);
            #1;
            r_rst = (n == 0) || ($urandom_range(0, 249) == 0);
            rst_n = !r_rst;
            if (!i_pend) begin
                if (i_linger) begin
                    i_linger = L;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.ic_read = H; bus.ic_addr = $urandom; i_pend = H;
                end else begin
                    bus.ic_read = L;
                end
            end
            if (!d_pend) begin
                if (d_linger) begin
                    d_linger = L;
                end else if ($urandom_range(0, 3) == 0) begin
                    bus.dc_addr = $urandom; bus.dc_wdata = rand_line(); d_pend = H;
                    if ($urandom_range(0, 1) == 0) begin
                        bus.dc_read = H; bus.dc_write = L;
                    end else begin
                        bus.dc_read = L; bus.dc_write = H;
                    end
                end else begin
                    bus.dc_read = L; bus.dc_write = L;
                end
            end
            if (owner != 0) begin
                if (mem_wait < 0) mem_wait = $urandom_range(0, 3);
                bus.mem_resp = (mem_wait == 0);
                if (mem_wait > 0) mem_wait--;
            end else begin
                bus.mem_resp = ($urandom_range(0, 7) == 0);
            end
            bus.mem_rdata = rand_line();
            #1;

            e_ir = (owner == 1) && bus.mem_resp;
            e_dr = (owner == 2) && bus.mem_resp;
            check_outputs($sformatf("rnd[%0d]", n), (owner != 0) && !cap_wr, (owner != 0) && cap_wr, cap_addr,
                          e_ir, e_dr, owner != 0,
                          e_ir ? bus.mem_rdata : z, (e_dr && !cap_wr) ? bus.mem_rdata : z, cap_wd);

            if (e_ir) begin i_pend = L; i_linger = 1'($urandom_range(0, 1)); end
            if (e_dr) begin d_pend = L; d_linger = 1'($urandom_range(0, 1)); end

            if (r_rst) begin
                owner = 0; last = FAVOR_D ? 1 : 2; ready_at = '{0, 0, 0}; mem_wait = -1;
                cap_addr = '0; cap_wd = '0; cap_wr = L;
            end else if (owner != 0) begin
                if (bus.mem_resp) begin
                    ready_at[owner] = now + 2;
                    owner = 0;
                    mem_wait = -1;
                end
            end else begin
                ei = bus.ic_read && (now >= ready_at[1]);
                ed = (bus.dc_read || bus.dc_write) && (now >= ready_at[2]);
                win = 0;
                if (ei && ed)  win = (last == 1) ? 2 : 1;
                else if (ei)   win = 1;
                else if (ed)   win = 2;
                if (win == 1) begin
                    cap_addr = bus.ic_addr & ~32'h1f; cap_wr = L; cap_wd = z;
                end else if (win == 2) begin
                    cap_addr = bus.dc_addr & ~32'h1f; cap_wr = bus.dc_write; cap_wd = bus.dc_write ? bus.dc_wdata : z;
                end
                if (win != 0) begin
                    owner = win;
                    last = win;
                end
            end
            now++;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/dfp_arbiter.md
# dfp_arbiter

Two-requester arbiter that shares the single line-granular memory port between the instruction cache and the data cache. It sits between the two caches' downward-facing ports (dfp_*) and the memory/burst interface. It grants one cache-line transaction at a time, either a 256-bit read or a 256-bit writeback, and holds the grant until memory responds. When both caches request at once, a round-robin pointer picks the winner.

## Interface
Parameters:
- ADDR_WIDTH, 32, byte address width on all ports
- LINE_WIDTH, 256, cache-line data width
- RESET_FAVOR_D, 1, round-robin pointer at reset: 1 = D-cache wins first tie, 0 = I-cache wins first tie

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- ic_addr  in  ADDR_WIDTH  I-cache line address
- ic_read  in  1  I-cache read request, level-held until ic_resp
- ic_rdata  out  LINE_WIDTH  line returned to I-cache
- ic_resp  out  1  one-cycle completion pulse to I-cache
- dc_addr  in  ADDR_WIDTH  D-cache line address
- dc_read  in  1  D-cache read request, level-held until dc_resp
- dc_write  in  1  D-cache writeback request, level-held until dc_resp
- dc_wdata  in  LINE_WIDTH  writeback line
- dc_rdata  out  LINE_WIDTH  line returned to D-cache
- dc_resp  out  1  one-cycle completion pulse to D-cache
- mem_addr  out  ADDR_WIDTH  line address; bits [4:0] always 0
- mem_read  out  1  memory read, held until mem_resp
- mem_write  out  1  memory write, held until mem_resp
- mem_wdata  out  LINE_WIDTH  write data
- mem_rdata  in  LINE_WIDTH  read data, valid with mem_resp
- mem_resp  in  1  memory completion, one cycle
- busy  out  1  high while a transaction is outstanding

## Operation
- States: IDLE, BUSY_I, BUSY_D.
- IDLE
  - A request is eligible if its read/write is high and that requester is not blocked (see Timing).
  - One eligible requester: capture addr (low 5 bits zeroed), op and wdata into registers. Go to BUSY_I or BUSY_D.
  - Both eligible: the winner is the one the round-robin pointer does not point to as last served.
  - The pointer updates to the winner on grant.
- dc_read and dc_write both high in the same cycle: the write is granted and the read is ignored. This is a protocol violation; the bench flags it.
- BUSY_x
  - mem_addr, mem_wdata and the op come from the capture registers.
  - mem_read or mem_write is held high.
  - Requester inputs are ignored; changes mid-transaction have no effect.
- mem_resp in BUSY_x
  - x_resp is high in the same cycle, combinationally.
  - x_rdata = mem_rdata in the same cycle for reads. For writes x_rdata = 0.
  - Next state is IDLE.
- ic_rdata and dc_rdata are 0 whenever the corresponding resp is low.
- mem_resp in IDLE is ignored; it covers a stale response after reset.
- Arithmetic: there is no address arithmetic. mem_addr = {captured_addr[ADDR_WIDTH-1:5], 5'b0}.

## Timing
- Reset (rst_n low at an edge)
  - State becomes IDLE, the pointer is set per RESET_FAVOR_D, and the blocked flags are cleared.
  - Capture registers are cleared to 0.
  - All outputs become 0 from the following cycle, including mid-transaction.
- Grant latency: a request visible in IDLE at cycle N produces mem_read/mem_write at cycle N+1. It stays high through the cycle mem_resp is seen and is low from the cycle after.
- Response latency: 0 cycles, mem_resp to x_resp.
- Blocking: the requester just served is ineligible for exactly one cycle after its resp, because its request line may still be high. The other requester may be granted in that cycle.
- Minimum back-to-back gap for the same requester: resp at M, next grant accepted at M+2, mem request at M+3.
- Alternating requesters: resp at M, other requester accepted at M+1, mem request at M+2.
- busy = (state != IDLE). It is low in the cycle after mem_resp.
- No timeout. A missing mem_resp holds BUSY indefinitely.

## Test plan
- Single I read
  - Stimulus: ic_read=1, ic_addr=0x1000_0024. Memory responds 3 cycles after mem_read with rdata=0xA5…A5.
  - Required: mem_addr=0x1000_0020, mem_read high for 4 cycles. ic_resp pulses for one cycle with ic_rdata=0xA5…A5. dc_resp stays 0.
- Simultaneous requests
  - Stimulus: reset with RESET_FAVOR_D=1, then ic_read and dc_read high together at cycle 0, both held.
  - Required: D is granted first. After dc_resp, I is granted at the next cycle. A third tie goes to D again.
- Dirty-miss sequence
  - Stimulus: dc_write with addr 0x2000_0040 and wdata 0x1234…, then dc_read with addr 0x3000_0040 immediately after dc_resp.
  - Required: mem_write with the exact wdata; dc_resp. Then one blocked cycle, then mem_read at 0x3000_0040.
- Held request not re-issued
  - Stimulus: ic_read kept high one cycle past ic_resp, then dropped.
  - Required: exactly one mem_read transaction; busy low after the response.
- Reset mid-transaction
  - Stimulus: rst_n low while in BUSY_D; memory asserts mem_resp one cycle after reset.
  - Required: mem_read/mem_write are 0 after the reset edge. The stale mem_resp produces no dc_resp or ic_resp. State is IDLE.
- Input change during BUSY
  - Stimulus: dc_addr and dc_wdata change while BUSY_D.
  - Required: mem_addr and mem_wdata keep their captured values until mem_resp.
